// File: rtl/pacman_turn_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_turn_buffer
//  Purpose  : Converts raw keyboard direction levels into one-hot direction
//             requests for the pacman motion FSM. Perpendicular turns are
//             held until pacman is tile-aligned; same-direction and reverse
//             turns are issued immediately. Each request is held up to and
//             including the next startOfFrame cycle.
//  Option   : TURN_BUFFER_EXPIRE_EN - buffered turns expire after
//             BUFFER_FRAMES frames without being issued.
//  Revision : 1.0 - initial release
// ============================================================================
module pacman_turn_buffer #(
    parameter int TILE_SIZE     = 32,
    parameter int GRID_OFFSET_X = 24,
    parameter int GRID_OFFSET_Y = 25,
    parameter int BUFFER_FRAMES = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_right,
    input  logic        key_left,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    output logic        up_req,
    output logic        down_req,
    output logic        right_req,
    output logic        left_req,
    output logic        pending_valid,
    output logic [1:0]  pending_dir,
    output logic [1:0]  cur_dir
);

    localparam logic [1:0]  DIR_DOWN  = 2'b00;
    localparam logic [1:0]  DIR_RIGHT = 2'b01;
    localparam logic [1:0]  DIR_LEFT  = 2'b10;
    localparam logic [1:0]  DIR_UP    = 2'b11;
    localparam logic [10:0] TILE_MASK = 11'(TILE_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_PENDING  = 2'd2,
        ST_ISSUE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  key_hist_q, key_hist_d;      // {up, down, right, left}
    logic [1:0]  pending_dir_q, pending_dir_d;
    logic [1:0]  cur_dir_q, cur_dir_d;
    logic        pending_valid_q, pending_valid_d;
    logic        chain_q, chain_d;            // new key latched while issuing

    logic [3:0]  key_now;
    logic [3:0]  key_rise;
    logic        key_edge;
    logic [1:0]  edge_dir;
    logic        edge_taken;
    logic [10:0] off_x, off_y;
    logic        aligned;
    logic        dir_direct;
    logic        expire;

    assign key_now  = {key_up, key_down, key_right, key_left};
    assign key_rise = key_now & ~key_hist_q;
    assign key_edge = |key_rise;

    // Simultaneous edges resolve up > down > right > left
    always_comb begin
        edge_dir = DIR_LEFT;
        if (key_rise[3])      edge_dir = DIR_UP;
        else if (key_rise[2]) edge_dir = DIR_DOWN;
        else if (key_rise[1]) edge_dir = DIR_RIGHT;
    end

    // Modulo-tile test; two's-complement wrap makes negative positions work
    assign off_x   = topLeftX - 11'(GRID_OFFSET_X);
    assign off_y   = topLeftY - 11'(GRID_OFFSET_Y);
    assign aligned = ((off_x & TILE_MASK) == 11'd0) && ((off_y & TILE_MASK) == 11'd0);

    // Reverse direction is the bitwise complement in this encoding
    assign dir_direct = (pending_dir_q == cur_dir_q) || (pending_dir_q == ~cur_dir_q);

    // An edge is only latched while the game runs and the FSM is out of IDLE
    assign edge_taken = key_edge && playGame && (state_q != ST_IDLE);

`ifdef TURN_BUFFER_EXPIRE_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Frame lifetime of the buffered turn: reload on latch, count down per frame
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (edge_taken)
            frame_cnt_d = 8'(BUFFER_FRAMES);
        else if (state_q == ST_PENDING && startOfFrame && frame_cnt_q != 8'd0)
            frame_cnt_d = frame_cnt_q - 8'd1;
    end

    // Frame counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) frame_cnt_q <= 8'd0;
        else         frame_cnt_q <= frame_cnt_d;
    end

    assign expire = (state_q == ST_PENDING) && startOfFrame && (frame_cnt_q == 8'd1);
`else
    // Expiry compiled out: a buffered turn lives until issued or flushed
    assign expire = (BUFFER_FRAMES < 0);
`endif

    // Next-state and buffered-turn bookkeeping
    always_comb begin
        state_d         = state_q;
        key_hist_d      = key_now;
        pending_dir_d   = pending_dir_q;
        pending_valid_d = pending_valid_q;
        cur_dir_d       = cur_dir_q;
        chain_d         = chain_q;

        if (!playGame) begin
            state_d         = ST_IDLE;
            pending_valid_d = 1'b0;
            pending_dir_d   = DIR_DOWN;
            chain_d         = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_KEY;
                end
                ST_WAIT_KEY: begin
                    if (key_edge) begin
                        pending_dir_d   = edge_dir;
                        pending_valid_d = 1'b1;
                        state_d         = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A fresh edge replaces the request; it is judged next cycle
                    if (key_edge) begin
                        pending_dir_d = edge_dir;
                    end else if (dir_direct || aligned) begin
                        cur_dir_d = pending_dir_q;
                        state_d   = ST_ISSUE;
                    end else if (expire) begin
                        pending_valid_d = 1'b0;
                        state_d         = ST_WAIT_KEY;
                    end
                end
                ST_ISSUE: begin
                    if (key_edge) begin
                        pending_dir_d = edge_dir;
                        chain_d       = 1'b1;
                    end
                    // Request is released after the frame boundary cycle
                    if (startOfFrame) begin
                        chain_d         = 1'b0;
                        pending_valid_d = chain_q || key_edge;
                        state_d         = (chain_q || key_edge) ? ST_PENDING : ST_WAIT_KEY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= ST_IDLE;
            key_hist_q      <= 4'd0;
            pending_dir_q   <= DIR_DOWN;
            pending_valid_q <= 1'b0;
            cur_dir_q       <= DIR_RIGHT;
            chain_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            key_hist_q      <= key_hist_d;
            pending_dir_q   <= pending_dir_d;
            pending_valid_q <= pending_valid_d;
            cur_dir_q       <= cur_dir_d;
            chain_q         <= chain_d;
        end
    end

    // Issued direction lives in cur_dir so a newly latched key cannot alter it
    assign up_req        = (state_q == ST_ISSUE) && (cur_dir_q == DIR_UP);
    assign down_req      = (state_q == ST_ISSUE) && (cur_dir_q == DIR_DOWN);
    assign right_req     = (state_q == ST_ISSUE) && (cur_dir_q == DIR_RIGHT);
    assign left_req      = (state_q == ST_ISSUE) && (cur_dir_q == DIR_LEFT);
    assign pending_valid = pending_valid_q;
    assign pending_dir   = pending_dir_q;
    assign cur_dir       = cur_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_pacman_turn_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pacman_turn_buffer
//  Purpose  : Self-checking bench for pacman_turn_buffer: directed vector
//             table, corner-case sequences and randomized run against a
//             behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pacman_turn_buffer;

    localparam int BF   = 3;
    localparam int TILE = 32;
    localparam int OFFX = 24;
    localparam int OFFY = 25;
`ifdef TURN_BUFFER_EXPIRE_EN
    localparam bit EXP = 1'b1;
`else
    localparam bit EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN, startOfFrame, playGame;
    logic        key_up, key_down, key_right, key_left;
    logic [10:0] topLeftX, topLeftY;
    logic        up_req, down_req, right_req, left_req, pending_valid;
    logic [1:0]  pending_dir, cur_dir;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pacman_turn_buffer #(
        .TILE_SIZE(TILE), .GRID_OFFSET_X(OFFX), .GRID_OFFSET_Y(OFFY), .BUFFER_FRAMES(BF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playGame(playGame),
        .key_up(key_up), .key_down(key_down), .key_right(key_right), .key_left(key_left),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .up_req(up_req), .down_req(down_req), .right_req(right_req), .left_req(left_req),
        .pending_valid(pending_valid), .pending_dir(pending_dir), .cur_dir(cur_dir)
    );

    // ---------------- behavioural reference model ----------------
    bit         m_idle, m_pv, m_iss, m_chain;
    logic [1:0] m_pd, m_cd;
    logic [3:0] m_hist;
    int         m_cnt;

    function automatic bit m_aligned(input logic [10:0] x, input logic [10:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return ((((sx - OFFX) % TILE) + TILE) % TILE == 0) &&
               ((((sy - OFFY) % TILE) + TILE) % TILE == 0);
    endfunction

    task automatic m_reset();
        m_idle = 1'b1; m_pv = 1'b0; m_iss = 1'b0; m_chain = 1'b0;
        m_pd = 2'b00; m_cd = 2'b01; m_hist = 4'd0; m_cnt = 0;
    endtask

    task automatic m_step(input bit play, input bit sof, input logic [3:0] keys,
                          input logic [10:0] x, input logic [10:0] y);
        logic [3:0] rise;
        logic [1:0] ed;
        bit e, al;
        rise = keys & ~m_hist;
        e    = |rise;
        ed   = rise[3] ? 2'b11 : rise[2] ? 2'b00 : rise[1] ? 2'b01 : 2'b10;
        al   = m_aligned(x, y);
        m_hist = keys;
        if (!play) begin
            m_idle = 1'b1; m_pv = 1'b0; m_pd = 2'b00; m_iss = 1'b0; m_chain = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_iss) begin
            if (e) begin m_pd = ed; m_chain = 1'b1; m_cnt = BF; end
            if (sof) begin m_iss = 1'b0; m_pv = m_chain; m_chain = 1'b0; end
        end else if (m_pv) begin
            if (e) begin
                m_pd = ed; m_cnt = BF;
            end else if (m_pd == m_cd || m_pd == ~m_cd || al) begin
                m_iss = 1'b1; m_cd = m_pd;
            end else if (EXP && sof) begin
                if (m_cnt == 1) m_pv = 1'b0;
                else m_cnt = m_cnt - 1;
            end
        end else if (e) begin
            m_pd = ed; m_pv = 1'b1; m_cnt = BF;
        end
    endtask

    function automatic logic [3:0] m_req();
        if (!m_iss) return 4'd0;
        case (m_cd)
            2'b11:   return 4'b1000;
            2'b00:   return 4'b0100;
            2'b01:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [3:0] dut_req();
        return {up_req, down_req, right_req, left_req};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input bit play, input bit sof, input logic [3:0] keys,
                        input logic [10:0] x, input logic [10:0] y);
        playGame = play; startOfFrame = sof;
        {key_up, key_down, key_right, key_left} = keys;
        topLeftX = x; topLeftY = y;
        m_step(play, sof, keys, x, y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; playGame = 1'b0; startOfFrame = 1'b0;
        {key_up, key_down, key_right, key_left} = 4'd0;
        topLeftX = 11'd0; topLeftY = 11'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        play, sof;
        logic [3:0]  keys;
        logic [10:0] x, y;
        logic [3:0]  req;
        logic        pv;
        logic [1:0]  pd, cd;
    } vec_t;

    function automatic vec_t mk(input int play, input int sof, input int keys, input int x,
                                input int y, input int req, input int pv, input int pd,
                                input int cd);
        vec_t v;
        v.play = play[0]; v.sof = sof[0]; v.keys = keys[3:0];
        v.x = x[10:0]; v.y = y[10:0]; v.req = req[3:0];
        v.pv = pv[0]; v.pd = pd[1:0]; v.cd = cd[1:0];
        return v;
    endfunction

    vec_t vecs[31];

    initial begin
        logic [3:0]  keys;
        logic [10:0] rx, ry;
        int          xi, yi;
        bit          play, sof;

        // keys/req bit order {up, down, right, left}; -8 = 2040, -7 = 2041
        vecs[0]  = mk(1,0,0, 280,185, 0,0,0,1);
        vecs[1]  = mk(1,0,8, 280,185, 0,1,3,1);
        vecs[2]  = mk(1,0,8, 280,185, 8,1,3,3);
        vecs[3]  = mk(1,0,8, 280,185, 8,1,3,3);
        vecs[4]  = mk(1,1,8, 280,185, 0,0,3,3);
        vecs[5]  = mk(1,0,0, 281,185, 0,0,3,3);
        vecs[6]  = mk(1,0,2, 281,185, 0,1,1,3);
        vecs[7]  = mk(1,0,2, 281,185, 0,1,1,3);
        vecs[8]  = mk(1,1,2, 281,185, 0,1,1,3);
        vecs[9]  = mk(1,0,2, 312,185, 2,1,1,1);
        vecs[10] = mk(1,1,2, 312,185, 0,0,1,1);
        vecs[11] = mk(1,0,0, 281,185, 0,0,1,1);
        vecs[12] = mk(1,0,1, 281,185, 0,1,2,1);
        vecs[13] = mk(1,0,1, 281,185, 1,1,2,2);
        vecs[14] = mk(1,1,1, 281,185, 0,0,2,2);
        vecs[15] = mk(1,0,0, 281,185, 0,0,2,2);
        vecs[16] = mk(1,0,9, 281,185, 0,1,3,2);
        vecs[17] = mk(1,0,11,281,185, 0,1,1,2);
        vecs[18] = mk(1,0,11,281,185, 2,1,1,1);
        vecs[19] = mk(1,1,0, 281,185, 0,0,1,1);
        vecs[20] = mk(1,0,0, 281,185, 0,0,1,1);
        vecs[21] = mk(1,0,4, 281,185, 0,1,0,1);
        vecs[22] = mk(1,0,4, 312,185, 4,1,0,0);
        vecs[23] = mk(1,0,5, 312,185, 4,1,2,0);
        vecs[24] = mk(1,1,5, 312,185, 0,1,2,0);
        vecs[25] = mk(1,0,5, 312,185, 1,1,2,2);
        vecs[26] = mk(1,1,0, 312,185, 0,0,2,2);
        vecs[27] = mk(1,0,0, 2040,2041, 0,0,2,2);
        vecs[28] = mk(1,0,8, 2040,2041, 0,1,3,2);
        vecs[29] = mk(1,0,8, 2040,2041, 8,1,3,3);
        vecs[30] = mk(1,1,0, 2040,2041, 0,0,3,3);

        do_reset();
        chk("reset_state", {dut_req(), pending_valid, pending_dir, cur_dir}, {4'd0, 1'b0, 2'b00, 2'b01});

        foreach (vecs[i]) begin
            tick(vecs[i].play, vecs[i].sof, vecs[i].keys, vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d", i), {dut_req(), pending_valid, pending_dir, cur_dir},
                {vecs[i].req, vecs[i].pv, vecs[i].pd, vecs[i].cd});
        end

        // Perpendicular turn never aligned: expires after BF frames, or lives on
        tick(1'b1, 1'b0, 4'd0, 11'd281, 11'd185);
        tick(1'b1, 1'b0, 4'd2, 11'd281, 11'd185);
        chk("exp_latch", {pending_valid, pending_dir}, {1'b1, 2'b01});
        for (int f = 1; f <= (EXP ? 5 : 100); f++) begin
            repeat (3) tick(1'b1, 1'b0, 4'd2, 11'd281, 11'd185);
            tick(1'b1, 1'b1, 4'd2, 11'd281, 11'd185);
            chk($sformatf("exp_pv_f%0d", f), pending_valid, (EXP && f >= BF) ? 1'b0 : 1'b1);
            chk($sformatf("exp_req_f%0d", f), dut_req(), 4'd0);
        end

        // playGame drop mid-ISSUE, then key edges ignored in IDLE
        tick(1'b0, 1'b0, 4'd0, 11'd281, 11'd185);
        chk("flush_pv", {pending_valid, pending_dir, cur_dir}, {1'b0, 2'b00, 2'b11});
        tick(1'b1, 1'b0, 4'd0, 11'd281, 11'd185);
        tick(1'b1, 1'b0, 4'd4, 11'd281, 11'd185);
        tick(1'b1, 1'b0, 4'd4, 11'd281, 11'd185);
        chk("rev_issue", {dut_req(), cur_dir}, {4'b0100, 2'b00});
        tick(1'b0, 1'b0, 4'd4, 11'd281, 11'd185);
        chk("drop_issue", {dut_req(), pending_valid, pending_dir, cur_dir}, {4'd0, 1'b0, 2'b00, 2'b00});
        tick(1'b0, 1'b0, 4'd8, 11'd281, 11'd185);
        chk("idle_ignore", {dut_req(), pending_valid}, {4'd0, 1'b0});
        tick(1'b1, 1'b0, 4'd8, 11'd281, 11'd185);
        tick(1'b1, 1'b0, 4'd8, 11'd281, 11'd185);
        chk("idle_no_edge", pending_valid, 1'b0);

        // Async reset in the middle of PENDING
        tick(1'b1, 1'b0, 4'd2, 11'd281, 11'd185);
        chk("pend_before_rst", {pending_valid, pending_dir}, {1'b1, 2'b01});
        #2 resetN = 1'b0;
        #1;
        chk("async_rst", {dut_req(), pending_valid, pending_dir, cur_dir}, {4'd0, 1'b0, 2'b00, 2'b01});

        // Randomized run against the model
        do_reset();
        keys = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) keys[b] = ~keys[b];
            play = ($urandom_range(0, 99) != 0);
            sof  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) begin
                xi = OFFX + TILE * ($urandom_range(0, 63) - 32);
                yi = OFFY + TILE * ($urandom_range(0, 63) - 32);
                rx = xi[10:0];
                ry = yi[10:0];
            end else begin
                rx = 11'($urandom);
                ry = 11'($urandom);
            end
            tick(play, sof, keys, rx, ry);
            chk($sformatf("rand%0d", c), {dut_req(), pending_valid, pending_dir, cur_dir},
                {m_req(), m_pv, m_pd, m_cd});
            chk("rand_onehot", ($countones(dut_req()) <= 1), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
